// File: rtl/jt7759_feeder.sv
// Host-side transmitter for the uPD7759 slave-mode data port.
// Bytes are buffered in a small FIFO; each falling edge of drqn is
// answered by exactly one registered cs=1/wrn=0 strobe carrying one byte.
module jt7759_feeder #(
  parameter int DEPTH  = 4,
  parameter int WR_LEN = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic [7:0]               load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     drqn,
  output logic                     cs,
  output logic                     wrn,
  output logic [7:0]               dout,
  output logic                     busy,
  output logic                     underrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;

  state_t          st, st_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd, wr;
  logic [CW-1:0]   cnt;
  logic            drqn_l, pending;
  logic            req_edge, push, pop, empty;

  assign req_edge   = drqn_l & ~drqn;
  assign empty      = (level == '0);
  assign load_ready = (level != LW'(DEPTH));
  assign push       = load_valid & load_ready & ~flush;
  assign busy       = (st != IDLE) | pending;

  // Next state; flush forces IDLE and suppresses the pop
  always_comb begin
    st_nxt = st;
    pop    = 1'b0;
    case (st)
      IDLE:   if (pending && !empty) begin
                pop    = 1'b1;
                st_nxt = STROBE;
              end
      STROBE: if (cnt == '0) st_nxt = HOLD;
      HOLD:   st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
    if (flush) begin
      st_nxt = IDLE;
      pop    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) st <= IDLE;
    else       st <= st_nxt;

  // Request edge detection, pending flag and underrun pulse
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      drqn_l   <= 1'b1;
      pending  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      drqn_l   <= drqn;
      underrun <= ~flush & req_edge & ~pending & empty & ~push;
      if (flush)         pending <= 1'b0;
      else if (pop)      pending <= 1'b0;  // an edge in the same cycle is absorbed
      else if (req_edge) pending <= 1'b1;
    end

  // FIFO storage; no reset needed, occupancy guards every read
  always_ff @(posedge clk)
    if (push) mem[wr] <= load_data;

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd    <= '0;
      wr    <= '0;
      level <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      level <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop)  rd <= rd + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end

  // Registered chip pins and strobe width counter; dout survives flush
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cs   <= 1'b0;
      wrn  <= 1'b1;
      dout <= '0;
      cnt  <= '0;
    end else if (flush) begin
      cs   <= 1'b0;
      wrn  <= 1'b1;
      cnt  <= '0;
    end else if (pop) begin
      dout <= mem[rd];
      cnt  <= CW'(WR_LEN - 1);
      cs   <= 1'b1;
      wrn  <= 1'b0;
    end else if (st == STROBE) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      else begin
        cs  <= 1'b0;
        wrn <= 1'b1;
      end
    end
endmodule

// File: tb/tb_jt7759_feeder.sv
// Directed bench: u0 uses WR_LEN=2, u1 uses WR_LEN=4 for the flush/reset case.
module tb_jt7759_feeder;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0, lv = 1'b0, drqn = 1'b1;
  logic [7:0] ld = 8'h00;
  logic       lr, cs, wrn, busy, und;
  logic [2:0] lvl;
  logic [7:0] dout;
  logic       flush1 = 1'b0, lv1 = 1'b0, drqn1 = 1'b1;
  logic [7:0] ld1 = 8'h00;
  logic       lr1, cs1, wrn1, busy1, und1;
  logic [2:0] lvl1;
  logic [7:0] dout1;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  jt7759_feeder #(.DEPTH(4), .WR_LEN(2)) u0 (
    .clk(clk), .rstn(rstn), .flush(flush), .load_data(ld), .load_valid(lv),
    .load_ready(lr), .level(lvl), .drqn(drqn), .cs(cs), .wrn(wrn),
    .dout(dout), .busy(busy), .underrun(und));

  jt7759_feeder #(.DEPTH(4), .WR_LEN(4)) u1 (
    .clk(clk), .rstn(rstn), .flush(flush1), .load_data(ld1), .load_valid(lv1),
    .load_ready(lr1), .level(lvl1), .drqn(drqn1), .cs(cs1), .wrn(wrn1),
    .dout(dout1), .busy(busy1), .underrun(und1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] b);
    ld = b; lv = 1'b1; step(); lv = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 10) begin step(); k++; end
    chk(tag, busy, 1'b0);
  endtask

  task automatic serve(input logic [7:0] exp, input string tag);
    int k = 0;
    drqn = 1'b0; step(); drqn = 1'b1;
    while (!cs && k < 8) begin step(); k++; end
    chk({tag, "_cs"}, cs, 1'b1);
    chk({tag, "_dout"}, dout, exp);
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int k;
    // reset values
    #12;
    chk("rst_cs", cs, 1'b0);   chk("rst_wrn", wrn, 1'b1);
    chk("rst_dout", dout, 8'h00); chk("rst_lvl", lvl, 3'd0);
    chk("rst_und", und, 1'b0); chk("rst_busy", busy, 1'b0);
    chk("rst_lr", lr, 1'b1);
    @(negedge clk); rstn = 1'b1; step();

    // single request: strobe 2 clk after fall, exactly 2 clk wide
    load(8'h11); load(8'h22); load(8'h33);
    chk("t1_lvl3", lvl, 3'd3);
    drqn = 1'b0; step();
    chk("t1_e1_cs", cs, 1'b0); chk("t1_e1_busy", busy, 1'b1);
    step();
    chk("t1_e2_cs", cs, 1'b1); chk("t1_e2_wrn", wrn, 1'b0);
    chk("t1_e2_dout", dout, 8'h11); chk("t1_e2_lvl", lvl, 3'd2);
    step();
    chk("t1_e3_cs", cs, 1'b1); chk("t1_e3_wrn", wrn, 1'b0);
    step();
    chk("t1_e4_cs", cs, 1'b0); chk("t1_e4_wrn", wrn, 1'b1);
    chk("t1_e4_hold_busy", busy, 1'b1); chk("t1_e4_dout", dout, 8'h11);
    step();
    chk("t1_e5_busy", busy, 1'b0);
    drqn = 1'b1; step(4);
    chk("t1_nomore_cs", cs, 1'b0); chk("t1_nomore_lvl", lvl, 3'd2);

    // drain, leaving pointers at 3 so the next fill wraps
    serve(8'h22, "t2_d22"); serve(8'h33, "t2_d33");
    chk("t2_empty", lvl, 3'd0);

    // fill to full; fifth byte rejected
    load(8'hA0); load(8'hA1); load(8'hA2); load(8'hA3);
    chk("t4_full_lvl", lvl, 3'd4); chk("t4_full_lr", lr, 1'b0);
    load(8'hEE);
    chk("t4_reject_lvl", lvl, 3'd4);

    // request with a push held: pop first, then the push lands
    drqn = 1'b0; ld = 8'hA4; lv = 1'b1; step(); drqn = 1'b1;
    chk("t4_pend_lvl", lvl, 3'd4);
    step();
    chk("t4_pop_cs", cs, 1'b1); chk("t4_pop_dout", dout, 8'hA0);
    chk("t4_pop_lvl", lvl, 3'd3);
    step(); lv = 1'b0;
    chk("t4_push_lvl", lvl, 3'd4);
    wait_idle("t4_idle");
    serve(8'hA1, "t2_a1"); serve(8'hA2, "t2_a2");
    serve(8'hA3, "t2_a3"); serve(8'hA4, "t4_a4_last");
    chk("t2_end_lvl", lvl, 3'd0);
    load(8'hB0); serve(8'hB0, "t2_wrap_b0");

    // underrun, second edge absorbed, late data served once
    drqn = 1'b0; step();
    chk("t3_und", und, 1'b1); chk("t3_busy", busy, 1'b1); chk("t3_cs", cs, 1'b0);
    drqn = 1'b1; step();
    chk("t3_und_pulse", und, 1'b0);
    drqn = 1'b0; step();
    chk("t5_und_once", und, 1'b0);
    drqn = 1'b1; step(7);
    chk("t3_nostrobe", cs, 1'b0); chk("t3_still_busy", busy, 1'b1);
    load(8'h5C);
    chk("t3_push_lvl", lvl, 3'd1); chk("t3_push_cs", cs, 1'b0);
    step();
    chk("t3_cs", cs, 1'b1); chk("t3_dout", dout, 8'h5C);
    wait_idle("t3_idle");
    step(4);
    chk("t5_one_strobe", cs, 1'b0); chk("t5_lvl", lvl, 3'd0);

    // flush during a WR_LEN=4 strobe
    ld1 = 8'h77; lv1 = 1'b1; step(); ld1 = 8'h88; step(); lv1 = 1'b0;
    drqn1 = 1'b0; step(); drqn1 = 1'b1;
    k = 0;
    while (!cs1 && k < 8) begin step(); k++; end
    chk("t6_cs", cs1, 1'b1); chk("t6_dout", dout1, 8'h77);
    step();
    chk("t6_cs_cyc2", cs1, 1'b1);
    flush1 = 1'b1; step(); flush1 = 1'b0;
    chk("t6_fl_cs", cs1, 1'b0); chk("t6_fl_wrn", wrn1, 1'b1);
    chk("t6_fl_lvl", lvl1, 3'd0); chk("t6_fl_busy", busy1, 1'b0);
    chk("t6_fl_dout", dout1, 8'h77);

    // async reset mid-strobe
    ld1 = 8'h99; lv1 = 1'b1; step(); lv1 = 1'b0;
    drqn1 = 1'b0; step(); drqn1 = 1'b1;
    k = 0;
    while (!cs1 && k < 8) begin step(); k++; end
    chk("t6_cs2", cs1, 1'b1);
    #1 rstn = 1'b0; #1;
    chk("t6_rst_cs", cs1, 1'b0); chk("t6_rst_wrn", wrn1, 1'b1);
    chk("t6_rst_lvl", lvl1, 3'd0); chk("t6_rst_busy", busy1, 1'b0);
    step(); rstn = 1'b1; step(2);
    chk("t6_after_cs", cs1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
